os_systolic_feeder: RTL and testbench
=====================================

# os_systolic_feeder

Input-staging controller that sits directly upstream of the output-stationary systolic array. It accepts one aligned operand vector per beat and skews each lane so operands meet at the correct PE: feature-map lane j is delayed j cycles and kernel lane i is delayed i cycles. It then flushes the pipeline with zeros and drives the array's `Op_sel` for the result-drain phase, so one `start` runs a complete accumulate-and-drain job.

## Interface
- `in_word_size`, 16, operand width per lane
- `row`, 5, number of kernel lanes (PE rows); must match the array
- `column`, 5, number of feature-map lanes (PE columns); must match the array
- `len_w`, 8, width of `k_len`
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  job-start pulse; sampled only in IDLE
- `k_len`  in  len_w  number of accumulation beats; sampled with `start`
- `in_valid`  in  1  operand vector valid
- `in_ready`  out  1  feeder accepts a vector this cycle
- `fmap_vec`  in  in_word_size × [0:column-1]  aligned feature-map operands
- `kernel_vec`  in  in_word_size × [0:row-1]  aligned kernel operands
- `fmap_out`  out  in_word_size × [0:column-1]  skewed feature-map operands to the array
- `kernel_out`  out  in_word_size × [0:row-1]  skewed kernel operands to the array
- `op_sel`  out  1  to the array's `Op_sel`: 0 = MAC, 1 = shift accumulated results out
- `busy`  out  1  job in progress
- `done`  out  1  single-cycle pulse when the drain phase completes

## Operation
- FSM states and transitions:
  - IDLE: `start && k_len != 0` → FEED, and latch `k_len`. If `k_len == 0`, `start` is ignored.
  - FEED → FLUSH on the cycle the k-th beat is accepted.
  - FLUSH lasts exactly `row+column-1` cycles, then → DRAIN.
  - DRAIN lasts exactly `column` cycles, then → IDLE with `done` pulsed.
- Beat acceptance: `in_valid && in_ready`. `in_ready` = 1 only in FEED. A beat counter of width `len_w` counts accepted beats only.
- Skew-stage input: each cycle, feed the accepted vector, or all-zero when no beat is accepted (FEED bubble, FLUSH, DRAIN, IDLE).
  - Zero bubbles add zero products, so accumulated results are unchanged.
  - The array has no stall input, and the feeder never stalls it.
- Skew lines: fmap lane j is a chain of j+1 registers; kernel lane i is a chain of i+1 registers. All registers are `in_word_size` wide with no arithmetic.
- `op_sel` = 1 exactly in DRAIN, and 0 otherwise.
- `busy` = 1 in FEED, FLUSH and DRAIN.
- A `start` pulse while `busy` is ignored; it is not queued.
- Reset (any state, including mid-job): the next cycle has state IDLE, all skew registers zero, counters zero, and every output 0 (`in_ready`, `op_sel`, `busy`, `done`, `fmap_out`, `kernel_out`). The in-flight job is abandoned.

## Timing
- Cycle t = the edge that samples `start`. FEED begins at t+1, so `in_ready` is first high at t+1.
- A vector accepted at cycle a appears on `fmap_out[j]` at cycle a+1+j and on `kernel_out[i]` at cycle a+1+i, each for exactly one cycle.
- Last beat accepted at cycle L:
  - FLUSH covers cycles L+1 … L+row+column−1.
  - DRAIN (`op_sel`=1) covers the next `column` cycles.
  - `done`=1 on the first IDLE cycle after DRAIN. In that cycle `busy`=0, and a `start` sampled in that cycle is accepted.
- With continuous `in_valid`, job length from `start` to `done` = 1 + k_len + (row+column−1) + column cycles.
- Beat counter: there is no wrap. It compares against the latched `k_len`, and the maximum is 2^len_w − 1.

## Test plan
- Reset: assert `rst` mid-FEED with non-zero data in the skew lines → on the next cycle all outputs are 0 and the state is IDLE; a following `start` with `k_len=2` runs a clean job.
- Skew, defaults: `start` with `k_len=1`, then one beat accepted at cycle a with `fmap_vec` all 7 and `kernel_vec[i]=i+1` → `fmap_out[j]=7` only at a+1+j; `kernel_out[i]=i+1` only at a+1+i; zero elsewhere.
- Full sequence: `k_len=3`, continuous valid → `in_ready` high for 3 cycles, FLUSH 9 cycles, `op_sel` high 5 cycles, `done` on the cycle after; `done` arrives 18 cycles after the `start` cycle.
- Bubbles: `k_len=3`, `in_valid` low for 2 cycles after the first beat → FEED lasts 5 cycles and `in_ready` stays high; zero vectors are injected at the correct skew; FLUSH/DRAIN durations are unchanged.
- Ignored starts: `start` with `k_len=0` in IDLE → no state change; `start` pulsed during FLUSH → current job completes unaffected and no second job begins.
- Back-to-back: `start` in the `done` cycle → new FEED begins the next cycle; `op_sel` drops to 0 before the first new beat.

Source files
------------

// File: rtl/os_systolic_feeder_if.sv
// Handshake and operand bus between the upstream staging logic, the feeder and the systolic array.
// The feeder attaches through the slave modport.
interface os_systolic_feeder_if #(
    parameter int unsigned in_word_size = 16,
    parameter int unsigned row          = 5,
    parameter int unsigned column       = 5,
    parameter int unsigned len_w        = 8
);
    logic                                  start;
    logic [len_w-1:0]                      k_len;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [0:column-1][in_word_size-1:0]   fmap_vec;
    logic [0:row-1][in_word_size-1:0]      kernel_vec;
    logic [0:column-1][in_word_size-1:0]   fmap_out;
    logic [0:row-1][in_word_size-1:0]      kernel_out;
    logic                                  op_sel;
    logic                                  busy;
    logic                                  done;

    modport master (
        output start, k_len, in_valid, fmap_vec, kernel_vec,
        input  in_ready, fmap_out, kernel_out, op_sel, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, fmap_vec, kernel_vec,
        output in_ready, fmap_out, kernel_out, op_sel, busy, done
    );
endinterface

// File: rtl/os_systolic_feeder.sv
// Skews aligned operand vectors into the output-stationary array, then flushes with zeros
// and drives op_sel for the result drain; one start runs a full accumulate-and-drain job.
module os_systolic_feeder #(
    parameter int unsigned in_word_size = 16,
    parameter int unsigned row          = 5,
    parameter int unsigned column       = 5,
    parameter int unsigned len_w        = 8
) (
    input  logic               clk,
    input  logic               rst,
    os_systolic_feeder_if.slave bus
);
    localparam int unsigned FLUSH_LEN = row + column - 1;
    localparam int unsigned PH_W      = $clog2(row + column);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

    state_t            state;
    logic [len_w-1:0]  klen;
    logic [len_w-1:0]  beat_cnt;
    logic [len_w-1:0]  beat_next;
    logic [PH_W-1:0]   phase;
    logic              in_ready_q;
    logic              op_sel_q;
    logic              busy_q;
    logic              done_q;
    logic              accept;

    assign accept    = in_ready_q && bus.in_valid;
    assign beat_next = beat_cnt + len_w'(1);

    // Job sequencer; outputs are registered from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            klen       <= '0;
            beat_cnt   <= '0;
            phase      <= '0;
            in_ready_q <= 1'b0;
            op_sel_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && (bus.k_len != '0)) begin
                        state      <= FEED;
                        klen       <= bus.k_len;
                        beat_cnt   <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                FEED: begin
                    if (accept) begin
                        if (beat_next == klen) begin
                            state      <= FLUSH;
                            beat_cnt   <= '0;
                            phase      <= '0;
                            in_ready_q <= 1'b0;
                        end else begin
                            beat_cnt <= beat_next;
                        end
                    end
                end
                FLUSH: begin
                    if (phase == PH_W'(FLUSH_LEN - 1)) begin
                        state    <= DRAIN;
                        phase    <= '0;
                        op_sel_q <= 1'b1;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                DRAIN: begin
                    if (phase == PH_W'(column - 1)) begin
                        state    <= IDLE;
                        phase    <= '0;
                        op_sel_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.op_sel   = op_sel_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    // Feature-map lane j: j+1 plain registers; zero enters whenever no beat is accepted.
    for (genvar j = 0; j < column; j++) begin : g_fmap
        logic [in_word_size-1:0] pipe [0:j];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= j; k++) pipe[k] <= '0;
            end else begin
                pipe[0] <= accept ? bus.fmap_vec[j] : '0;
                for (int k = 1; k <= j; k++) pipe[k] <= pipe[k-1];
            end
        end
        assign bus.fmap_out[j] = pipe[j];
    end

    // Kernel lane i: i+1 plain registers.
    for (genvar i = 0; i < row; i++) begin : g_kern
        logic [in_word_size-1:0] pipe [0:i];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= i; k++) pipe[k] <= '0;
            end else begin
                pipe[0] <= accept ? bus.kernel_vec[i] : '0;
                for (int k = 1; k <= i; k++) pipe[k] <= pipe[k-1];
            end
        end
        assign bus.kernel_out[i] = pipe[i];
    end
endmodule

// File: tb/tb_os_systolic_feeder.sv
// Self-checking bench for os_systolic_feeder: job-timeline reference model checked every cycle,
// a table of job shapes with expected feed/latency counts, and hand sequences for corner cases.
module tb_os_systolic_feeder;
    localparam int unsigned W  = 16;
    localparam int unsigned R  = 5;
    localparam int unsigned C  = 5;
    localparam int unsigned LW = 8;
    localparam int unsigned VW = 128;
    localparam int MAXE = 16384;

    typedef logic [0:C-1][W-1:0] fvec_t;
    typedef logic [0:R-1][W-1:0] kvec_t;
    typedef struct {
        int k;
        int gap;
        int exp_ready;
        int exp_lat;
    } job_vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    os_systolic_feeder_if #(.in_word_size(W), .row(R), .column(C), .len_w(LW)) bus ();
    os_systolic_feeder #(.in_word_size(W), .row(R), .column(C), .len_w(LW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int e = 0;

    fvec_t hist_f [MAXE];
    kvec_t hist_k [MAXE];
    int rst_edge = -1;
    bit m_feed = 1'b0;
    bit m_job = 1'b0;
    int m_left = 0;
    int m_last = 0;
    bit exp_ready, exp_op, exp_busy, exp_done;
    fvec_t exp_f;
    kvec_t exp_k;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, exp);
        end
    endtask

    // Reference: a job is a timeline keyed on the edge of its last accepted beat.
    task automatic model_edge();
        bit accept, idle_pre;
        int done_edge;
        done_edge = m_last + int'(R) + 2 * int'(C) - 1;
        accept    = m_feed && (bus.in_valid === 1'b1);
        idle_pre  = !m_feed && (!m_job || (e - 1 >= done_edge));
        hist_f[e] = accept ? bus.fmap_vec   : '0;
        hist_k[e] = accept ? bus.kernel_vec : '0;
        if (rst) begin
            m_feed   = 1'b0;
            m_job    = 1'b0;
            rst_edge = e;
        end else if (m_feed) begin
            if (accept) begin
                m_left--;
                if (m_left == 0) begin
                    m_feed = 1'b0;
                    m_job  = 1'b1;
                    m_last = e;
                end
            end
        end else if (idle_pre && bus.start && (bus.k_len != '0)) begin
            m_feed = 1'b1;
            m_left = int'(bus.k_len);
        end
        done_edge = m_last + int'(R) + 2 * int'(C) - 1;
        exp_ready = m_feed;
        exp_op    = m_job && (e >= m_last + int'(R) + int'(C) - 1) && (e < done_edge);
        exp_done  = m_job && (e == done_edge);
        exp_busy  = m_feed || (m_job && (e < done_edge));
        for (int j = 0; j < int'(C); j++)
            exp_f[j] = (e - j > rst_edge) ? hist_f[e - j][j] : '0;
        for (int i = 0; i < int'(R); i++)
            exp_k[i] = (e - i > rst_edge) ? hist_k[e - i][i] : '0;
    endtask

    task automatic tick();
        if (e >= MAXE) begin
            $display("FAIL edge_budget: got %0d edges, limit %0d", e, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        @(posedge clk);
        model_edge();
        #1;
        chk("ctrl{in_ready,op_sel,busy,done}",
            VW'({bus.in_ready, bus.op_sel, bus.busy, bus.done}),
            VW'({exp_ready, exp_op, exp_busy, exp_done}));
        chk("fmap_out", VW'(bus.fmap_out), VW'(exp_f));
        chk("kernel_out", VW'(bus.kernel_out), VW'(exp_k));
        e++;
    endtask

    task automatic rand_data();
        for (int j = 0; j < int'(C); j++) bus.fmap_vec[j] = W'($urandom);
        for (int i = 0; i < int'(R); i++) bus.kernel_vec[i] = W'($urandom);
    endtask

    task automatic run_job(input int k, input int gap, output int ready_cnt, output int lat);
        int start_e, sent, gapleft;
        bus.start = 1'b1;
        bus.k_len = LW'(k);
        bus.in_valid = 1'b0;
        rand_data();
        start_e = e;
        tick();
        bus.start = 1'b0;
        ready_cnt = bus.in_ready ? 1 : 0;
        sent = 0;
        gapleft = gap;
        lat = -1;
        for (int n = 0; n < 2000 && lat < 0; n++) begin
            rand_data();
            if (sent == 1 && gapleft > 0) begin
                bus.in_valid = 1'b0;
                gapleft--;
            end else begin
                bus.in_valid = (sent < k);
            end
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
            if (bus.in_ready) ready_cnt++;
            if (bus.done) lat = (e - 1) - start_e + 1;
        end
        bus.in_valid = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: got no done within 2000 cycles, expected done for k_len=%0d", k);
        end
    endtask

    job_vec_t tbl [7];

    initial begin
        int rc, lat, a;
        tbl[0] = '{k: 1,   gap: 0, exp_ready: 1,   exp_lat: 16};
        tbl[1] = '{k: 3,   gap: 0, exp_ready: 3,   exp_lat: 18};
        tbl[2] = '{k: 3,   gap: 2, exp_ready: 5,   exp_lat: 20};
        tbl[3] = '{k: 4,   gap: 1, exp_ready: 5,   exp_lat: 20};
        tbl[4] = '{k: 8,   gap: 0, exp_ready: 8,   exp_lat: 23};
        tbl[5] = '{k: 2,   gap: 3, exp_ready: 5,   exp_lat: 20};
        tbl[6] = '{k: 255, gap: 0, exp_ready: 255, exp_lat: 270};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.in_valid = 1'b0;
        rand_data();
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Job shapes run back-to-back: each start lands in the previous job's done cycle.
        for (int t = 0; t < 7; t++) begin
            run_job(tbl[t].k, tbl[t].gap, rc, lat);
            chk("ready_cycles", VW'(rc), VW'(tbl[t].exp_ready));
            chk("start_to_done", VW'(lat), VW'(tbl[t].exp_lat));
        end
        bus.start = 1'b0;
        repeat (3) tick();

        // k_len = 0 start is ignored.
        bus.start = 1'b1;
        bus.k_len = '0;
        tick();
        bus.start = 1'b0;
        chk("kzero_busy", VW'(bus.busy), VW'(0));
        chk("kzero_ready", VW'(bus.in_ready), VW'(0));
        tick();

        // Skew with defaults: fmap all 7, kernel lane i = i+1.
        bus.start = 1'b1;
        bus.k_len = LW'(1);
        tick();
        bus.start = 1'b0;
        for (int j = 0; j < int'(C); j++) bus.fmap_vec[j] = W'(7);
        for (int i = 0; i < int'(R); i++) bus.kernel_vec[i] = W'(i + 1);
        bus.in_valid = 1'b1;
        a = e;
        tick();
        bus.in_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            int d;
            d = (e - 1) - a;
            if (d >= 0 && d < int'(C)) chk("skew_fmap", VW'(bus.fmap_out[d]), VW'(7));
            if (d >= 0 && d < int'(R)) chk("skew_kernel", VW'(bus.kernel_out[d]), VW'(d + 1));
            rand_data();
            tick();
        end

        // Start pulsed during FLUSH is dropped.
        run_job(2, 0, rc, lat);
        chk("flush_job_lat", VW'(lat), VW'(17));
        bus.start = 1'b1;
        bus.k_len = LW'(2);
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        repeat (2) tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        bus.start = 1'b1;
        bus.k_len = LW'(4);
        tick();
        bus.start = 1'b0;
        repeat (20) tick();
        chk("no_second_job", VW'({bus.busy, bus.in_ready}), VW'(0));

        // Reset mid-FEED with live data in the skew lines.
        bus.start = 1'b1;
        bus.k_len = LW'(6);
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        repeat (3) begin
            for (int j = 0; j < int'(C); j++) bus.fmap_vec[j] = W'(16'h1000 + j);
            for (int i = 0; i < int'(R); i++) bus.kernel_vec[i] = W'(16'h2000 + i);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("rst_ctrl", VW'({bus.in_ready, bus.op_sel, bus.busy, bus.done}), VW'(0));
        chk("rst_fmap", VW'(bus.fmap_out), VW'(0));
        chk("rst_kernel", VW'(bus.kernel_out), VW'(0));
        run_job(2, 0, rc, lat);
        chk("post_rst_lat", VW'(lat), VW'(17));

        // Randomized traffic with stray starts, zero k_len and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.start = ($urandom_range(0, 5) == 0);
            bus.k_len = LW'($urandom_range(0, 9));
            bus.in_valid = ($urandom_range(0, 3) != 0);
            rand_data();
            tick();
        end
        rst = 1'b0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        repeat (30) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
